splice_sched: RTL and testbench

SPLICE_SCHED -- requirements
Module: splice_sched

---
 rtl/splice_sched.sv | 103 ++++++++++
 tb/tb_splice_sched.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/splice_sched.sv
// splice_sched: two-requester round-robin scheduler in front of a shared,
// fixed-latency splice resource. One operation is in flight at a time.
module splice_sched #(
  parameter int unsigned LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  input  logic        req1_valid,
  input  logic [7:0]  req0_data,
  input  logic [7:0]  req1_data,
  output logic        req0_ready,
  output logic        req1_ready,
  output logic [7:0]  res_i,
  input  logic [7:0]  res_o,
  output logic        rsp0_valid,
  output logic        rsp1_valid,
  output logic [7:0]  rsp_data,
  output logic        busy,
  output logic [15:0] op_count
);

  typedef enum logic [1:0] {IDLE, RUN, RESP} state_t;

  localparam logic [3:0] LAT4 = 4'(LATENCY);

  state_t      state_q;
  logic        ptr_q;
  logic [3:0]  cnt_q;
  logic [7:0]  opnd_q;
  logic        id_q;
  logic [3:0]  res_q;
  logic [15:0] op_count_q;

  logic        gnt0;
  logic        gnt1;
  logic        unused_res_hi;

  // Only the low nibble of the resource result reaches the response.
  assign unused_res_hi = ^res_o[7:4];

  // Grant decode: a lone requester wins outright, contention follows the pointer.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!rst && state_q == IDLE) begin
      gnt0 = req0_valid && (!req1_valid || !ptr_q);
      gnt1 = req1_valid && (!req0_valid ||  ptr_q);
    end
  end

  // Output decode; everything is forced quiet while reset is held.
  always_comb begin
    req0_ready = gnt0;
    req1_ready = gnt1;
    busy       = !rst && (state_q != IDLE);
    res_i      = (!rst && state_q == RUN) ? opnd_q : '0;
    rsp0_valid = !rst && (state_q == RESP) && !id_q;
    rsp1_valid = !rst && (state_q == RESP) &&  id_q;
    rsp_data   = (!rst && state_q == RESP) ? {opnd_q[7:4], res_q} : '0;
    op_count   = op_count_q;
  end

  // Sequencer: capture on grant, hold operand for LATENCY cycles, respond once.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      ptr_q      <= 1'b0;
      cnt_q      <= '0;
      opnd_q     <= '0;
      id_q       <= 1'b0;
      res_q      <= '0;
      op_count_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (gnt0 || gnt1) begin
            opnd_q  <= gnt1 ? req1_data : req0_data;
            id_q    <= gnt1;
            ptr_q   <= gnt0;
            cnt_q   <= LAT4;
            state_q <= RUN;
          end
        end
        RUN: begin
          if (cnt_q == 4'd1) begin
            res_q   <= res_o[3:0];
            cnt_q   <= '0;
            state_q <= RESP;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        RESP: begin
          op_count_q <= op_count_q + 16'd1;
          state_q    <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_splice_sched.sv
// tb_splice_sched: scoreboard bench for splice_sched at LATENCY 2, 1 and 15.
// The resource model returns the bitwise inverse of its operand.
module tb_splice_sched;

  typedef struct packed {
    logic        id;
    logic [7:0]  data;
    int unsigned due;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst[3];
  logic        v0[3], v1[3], r0[3], r1[3], s0[3], s1[3], bz[3];
  logic [7:0]  d0[3], d1[3], res_i[3], res_o[3], rd[3];
  logic [15:0] oc[3];

  int unsigned cyc   = 0;
  int unsigned total = 0;
  int unsigned bad   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  for (genvar k = 0; k < 3; k++) begin : g
    localparam int unsigned L = (k == 0) ? 2 : ((k == 1) ? 1 : 15);

    splice_sched #(.LATENCY(L)) u_dut (
      .clk(clk), .rst(rst[k]),
      .req0_valid(v0[k]), .req1_valid(v1[k]),
      .req0_data(d0[k]), .req1_data(d1[k]),
      .req0_ready(r0[k]), .req1_ready(r1[k]),
      .res_i(res_i[k]), .res_o(res_o[k]),
      .rsp0_valid(s0[k]), .rsp1_valid(s1[k]),
      .rsp_data(rd[k]), .busy(bz[k]), .op_count(oc[k])
    );

    assign res_o[k] = ~res_i[k];

    exp_t        sb[$];
    logic        gid[$];
    int unsigned gcyc[$];
    int unsigned run_left = 0;
    logic [7:0]  hold = '0;
    logic [15:0] exp_cnt = '0;
    logic [7:0]  last_data = '0;

    always @(negedge clk) begin
      exp_t e;
      logic gi;
      logic [7:0] gd;
      if (rst[k]) begin
        check("rst_out", {11'b0, r0[k], r1[k], s0[k], s1[k], bz[k], res_i[k], rd[k]}, '0);
        sb.delete();
        run_left = 0;
        exp_cnt  = '0;
      end else begin
        check("both_ready", {31'b0, r0[k] & r1[k]}, '0);
        if (!v0[k]) check("spur_ready0", {31'b0, r0[k]}, '0);
        if (!v1[k]) check("spur_ready1", {31'b0, r1[k]}, '0);
        if (sb.size() != 0) check("ready_busy", {31'b0, r0[k] | r1[k]}, '0);
        check("busy", {31'b0, bz[k]}, {31'b0, sb.size() != 0});
        check("op_count", {16'b0, oc[k]}, {16'b0, exp_cnt});
        if (run_left > 0) begin
          check("res_i_run", {24'b0, res_i[k]}, {24'b0, hold});
          run_left--;
        end else begin
          check("res_i_idle", {24'b0, res_i[k]}, '0);
        end
        if (s0[k] || s1[k]) begin
          if (sb.size() == 0) begin
            check("spur_rsp", 32'd1, 32'd0);
          end else begin
            e = sb.pop_front();
            check("rsp_both", {31'b0, s0[k] & s1[k]}, '0);
            check("rsp_id", {31'b0, s1[k]}, {31'b0, e.id});
            check("rsp_data", {24'b0, rd[k]}, {24'b0, e.data});
            check("rsp_time", cyc, e.due);
            last_data = rd[k];
            exp_cnt   = exp_cnt + 16'd1;
          end
        end else begin
          check("rsp_data_idle", {24'b0, rd[k]}, '0);
          if (sb.size() != 0 && cyc > sb[0].due) begin
            check("rsp_timeout", cyc, sb[0].due);
            void'(sb.pop_front());
          end
        end
        if ((r0[k] && v0[k]) || (r1[k] && v1[k])) begin
          gi = r1[k] && v1[k];
          gd = gi ? d1[k] : d0[k];
          sb.push_back('{id: gi, data: {gd[7:4], ~gd[3:0]}, due: cyc + L + 1});
          hold     = gd;
          run_left = L;
          gid.push_back(gi);
          gcyc.push_back(cyc);
        end
      end
    end
  end

  task automatic do_reset();
    for (int i = 0; i < 3; i++) begin
      rst[i] = 1'b1; v0[i] = 1'b0; v1[i] = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) rst[i] = 1'b0;
  endtask

  // Raise valid, wait (bounded) for the grant, then drop valid after the transfer edge.
  task automatic issue(input int k, input logic id, input logic [7:0] d);
    logic got;
    got = 1'b0;
    if (id) begin v1[k] = 1'b1; d1[k] = d; end
    else    begin v0[k] = 1'b1; d0[k] = d; end
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (id ? r1[k] : r0[k]) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) check("grant_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    if (id) v1[k] = 1'b0; else v0[k] = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      rst[i] = 1'b1; v0[i] = 1'b0; v1[i] = 1'b0; d0[i] = '0; d1[i] = '0;
    end
    do_reset();

    // Single op on req0, requested in the very first cycle out of reset.
    issue(0, 1'b0, 8'h5C);
    idle(5);
    check("op1_count", {16'b0, oc[0]}, 32'd1);
    check("op1_data", {24'b0, g[0].last_data}, 32'h53);

    // Continuous contention from reset: alternating grants, 4 cycles apart.
    do_reset();
    g[0].gid.delete();
    g[0].gcyc.delete();
    d0[0] = 8'h1A; d1[0] = 8'hB2;
    v0[0] = 1'b1;  v1[0] = 1'b1;
    idle(14);
    v0[0] = 1'b0;  v1[0] = 1'b0;
    idle(6);
    check("cont_grants", g[0].gid.size(), 32'd4);
    for (int i = 0; i < 4 && i < g[0].gid.size(); i++) begin
      check("cont_order", {31'b0, g[0].gid[i]}, i % 2);
      if (i > 0) check("cont_space", g[0].gcyc[i] - g[0].gcyc[i-1], 32'd4);
    end

    // Reset in the first RUN cycle abandons the op; grant right after release.
    issue(0, 1'b0, 8'h77);
    for (int i = 0; i < 3; i++) rst[i] = 1'b1;
    idle(1);
    for (int i = 0; i < 3; i++) rst[i] = 1'b0;
    v1[0] = 1'b1; d1[0] = 8'h42;
    @(negedge clk);
    check("grant_after_rst", {31'b0, r1[0]}, 32'd1);
    check("count_after_rst", {16'b0, oc[0]}, 32'd0);
    @(posedge clk); #1;
    v1[0] = 1'b0;
    idle(6);

    // Operand stability: requester data churns and req0 pulses while busy.
    issue(0, 1'b1, 8'h9E);
    for (int n = 0; n < 3; n++) begin
      d1[0] = 8'($urandom);
      d0[0] = 8'($urandom);
      v0[0] = (n % 2 == 0);
      idle(1);
    end
    v0[0] = 1'b0;
    idle(3);
    check("stable_data", {24'b0, g[0].last_data}, 32'h91);

    // Wrap: preload the completion counter just below rollover.
    force g[0].u_dut.op_count_q = 16'hFFFF;
    g[0].exp_cnt = 16'hFFFF;
    #1 release g[0].u_dut.op_count_q;
    idle(1);
    issue(0, 1'b0, 8'h3C);
    idle(5);
    check("wrap", {16'b0, oc[0]}, 32'd0);

    // Latency extremes with idle gaps between operations.
    issue(1, 1'b1, 8'hC7);
    idle(25);
    issue(1, 1'b0, 8'h3B);
    idle(6);
    issue(2, 1'b1, 8'hE1);
    idle(25);
    issue(2, 1'b0, 8'h1F);
    idle(20);

    check("sb_drain0", g[0].sb.size(), 32'd0);
    check("sb_drain1", g[1].sb.size(), 32'd0);
    check("sb_drain2", g[2].sb.size(), 32'd0);
    check("count_l1", {16'b0, oc[1]}, 32'd2);
    check("count_l15", {16'b0, oc[2]}, 32'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
